// File: rtl/serial_word_packer_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// serial_word_packer_pkg : shared word/counter widths for packer and reducer
// Revision: 1.0
// ---------------------------------------------------------------------------
package serial_word_packer_pkg;

  localparam int WORD_WIDTH  = 4;
  localparam int COUNT_WIDTH = 8;

  // Width of a counter that must hold 0..width-1; never narrower than 1 bit.
  function automatic int fill_width(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage : serial_word_packer_pkg
`default_nettype wire

// File: rtl/serial_shift_reg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// serial_shift_reg : WIDTH-bit serial-in shifter with sync clear
// Revision: 1.0
// ---------------------------------------------------------------------------
module serial_shift_reg #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clear,
  input  logic             i_shift,
  input  logic             i_bit,
  output logic [WIDTH-1:0] o_next
);

  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] w_next;

  // o_next is the value after shifting in i_bit, so the top can capture a
  // completed word on the same edge that accepts its final bit.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_next = {r_sr[WIDTH-2:0], i_bit};
    end else begin : g_lsb_first
      assign w_next = {i_bit, r_sr[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr <= '0;
    end else if (i_clear) begin
      r_sr <= '0;
    end else if (i_shift) begin
      r_sr <= w_next;
    end
  end

  assign o_next = w_next;

endmodule : serial_shift_reg
`default_nettype wire

// File: rtl/serial_word_packer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// serial_word_packer : packs a serial bit stream into WIDTH-bit words with
//                      valid/ready output and backpressure on the bit source
// Revision: 1.0
// ---------------------------------------------------------------------------
module serial_word_packer
  import serial_word_packer_pkg::*;
#(
  parameter int WIDTH     = WORD_WIDTH,
  parameter bit MSB_FIRST = 1'b1,
  parameter int CNT_W     = COUNT_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clear,
  input  logic                          bit_in,
  input  logic                          bit_valid,
  output logic                          bit_ready,
  output logic [WIDTH-1:0]              word_out,
  output logic                          word_valid,
  input  logic                          word_ready,
  output logic [fill_width(WIDTH)-1:0]  fill_level,
  output logic [CNT_W-1:0]              word_count
);

  localparam int                c_FW   = fill_width(WIDTH);
  localparam logic [c_FW-1:0]   c_LAST = c_FW'(WIDTH - 1);

  logic [c_FW-1:0]  r_fill;
  logic [WIDTH-1:0] r_word;
  logic             r_valid;
  logic [CNT_W-1:0] r_count;

  logic             w_last;
  logic             w_ready;
  logic             w_accept;
  logic             w_complete;
  logic             w_handshake;
  logic [WIDTH-1:0] w_next_word;

  assign w_last      = (r_fill == c_LAST);
  // Only the word-completing bit can stall: it needs a free output slot.
  assign w_ready     = !(w_last && r_valid && !word_ready);
  assign w_accept    = bit_valid && w_ready && !clear;
  assign w_complete  = w_accept && w_last;
  assign w_handshake = r_valid && word_ready && !clear;

  serial_shift_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (clear),
    .i_shift (w_accept),
    .i_bit   (bit_in),
    .o_next  (w_next_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fill  <= '0;
      r_word  <= '0;
      r_valid <= 1'b0;
      r_count <= '0;
    end else if (clear) begin
      r_fill  <= '0;
      r_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_fill <= w_last ? '0 : r_fill + c_FW'(1);
      end
      if (w_complete) begin
        r_word  <= w_next_word;
        r_valid <= 1'b1;
      end else if (w_handshake) begin
        r_valid <= 1'b0;
      end
      if (w_handshake) begin
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

  assign bit_ready  = w_ready;
  assign word_out   = r_word;
  assign word_valid = r_valid;
  assign fill_level = r_fill;
  assign word_count = r_count;

endmodule : serial_word_packer
`default_nettype wire

// File: tb/tb_serial_word_packer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_serial_word_packer : MSB- and LSB-first packers checked against a
//                         bit-queue reference model
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_serial_word_packer;

  localparam int WIDTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;
  logic bit_in = 1'b0;
  logic bit_valid = 1'b0;
  logic word_ready = 1'b0;

  logic       bit_ready,   bit_ready_l;
  logic [3:0] word_out,    word_out_l;
  logic       word_valid,  word_valid_l;
  logic [1:0] fill_level,  fill_l;
  logic [7:0] word_count,  count_l;

  int checks = 0;
  int failures = 0;

  // Reference model: bits collected so far, the pending word in both orders.
  bit       m_bits[$];
  bit       m_valid;
  bit [3:0] m_wm;
  bit [3:0] m_wl;
  int       m_count;

  serial_word_packer #(.WIDTH(4), .MSB_FIRST(1'b1), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .bit_in(bit_in),
    .bit_valid(bit_valid), .bit_ready(bit_ready), .word_out(word_out),
    .word_valid(word_valid), .word_ready(word_ready),
    .fill_level(fill_level), .word_count(word_count)
  );

  serial_word_packer #(.WIDTH(4), .MSB_FIRST(1'b0), .CNT_W(8)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .clear(clear), .bit_in(bit_in),
    .bit_valid(bit_valid), .bit_ready(bit_ready_l), .word_out(word_out_l),
    .word_valid(word_valid_l), .word_ready(word_ready),
    .fill_level(fill_l), .word_count(count_l)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] act_vec();
    return {bit_ready, word_valid, fill_level, word_count, word_out,
            bit_ready_l, word_valid_l, fill_l, count_l, word_out_l};
  endfunction

  function automatic logic [31:0] exp_vec();
    logic       r;
    logic [1:0] f;
    logic [7:0] c;
    r = !(m_bits.size() == WIDTH - 1 && m_valid && !word_ready);
    f = 2'(m_bits.size());
    c = 8'(m_count % 256);
    return {r, m_valid, f, c, m_wm, r, m_valid, f, c, m_wl};
  endfunction

  task automatic model_reset();
    m_bits.delete();
    m_valid = 1'b0;
    m_wm    = '0;
    m_wl    = '0;
    m_count = 0;
  endtask

  // One clock: the model decides acceptance from the inputs held across the edge.
  task automatic step();
    bit rdy, acc, hs;
    rdy = !(m_bits.size() == WIDTH - 1 && m_valid && !word_ready);
    acc = bit_valid && rdy && !clear;
    hs  = m_valid && word_ready && !clear;
    @(posedge clk);
    if (clear) begin
      m_bits.delete();
      m_valid = 1'b0;
    end else begin
      if (hs) begin
        m_count++;
        m_valid = 1'b0;
      end
      if (acc) begin
        m_bits.push_back(bit_in);
        if (m_bits.size() == WIDTH) begin
          for (int i = 0; i < WIDTH; i++) begin
            m_wm[WIDTH-1-i] = m_bits[i];
            m_wl[i]         = m_bits[i];
          end
          m_valid = 1'b1;
          m_bits.delete();
        end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    @(posedge clk);
    #1;
    clear = 1'b0; bit_valid = 1'b0; word_ready = 1'b0; bit_in = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    model_reset();
    #3;
    checks++;
    if ((act_vec() & 32'h7FFF_7FFF) !== 32'h0) begin
      failures++;
      $display("FAIL reset_state: got %h expected %h", act_vec() & 32'h7FFF_7FFF, 32'h0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    checks++;
    if ({bit_ready, bit_ready_l} !== 2'b11) begin
      failures++;
      $display("FAIL reset_ready: got %b expected 11", {bit_ready, bit_ready_l});
    end
  endtask

  task automatic test_basic();
    logic [3:0] pat = 4'b1011;
    do_reset();
    word_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bit_valid = 1'b1;
      bit_in    = pat[3-i];
      step();
      checks++;
      if (act_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL basic_cycle: got %h expected %h", act_vec(), exp_vec());
      end
    end
    bit_valid = 1'b0;
    checks++;
    if ({word_valid, word_out, word_out_l} !== {1'b1, 4'b1011, 4'b1101}) begin
      failures++;
      $display("FAIL basic_word: got %b expected %b", {word_valid, word_out, word_out_l}, 9'b1_1011_1101);
    end
    step();
    checks++;
    if ({word_valid, word_count} !== {1'b0, 8'd1}) begin
      failures++;
      $display("FAIL basic_one_cycle: got %h expected %h", {word_valid, word_count}, 9'h001);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] pat = 8'b1111_0000;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      bit_valid = 1'b1;
      bit_in    = pat[7-i];
      step();
      checks++;
      if (act_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL bp_cycle: got %h expected %h", act_vec(), exp_vec());
      end
    end
    bit_in = pat[0];
    #1;
    checks++;
    if ({bit_ready, fill_level, word_valid, word_out} !== {1'b0, 2'd3, 1'b1, 4'b1111}) begin
      failures++;
      $display("FAIL bp_stall: got %b expected %b", {bit_ready, fill_level, word_valid, word_out}, 8'b0_11_1_1111);
    end
    repeat (2) step();
    checks++;
    if ({fill_level, word_out, word_count} !== {2'd3, 4'b1111, 8'd0}) begin
      failures++;
      $display("FAIL bp_hold: got %h expected %h", {fill_level, word_out, word_count}, {2'd3, 4'b1111, 8'd0});
    end
    word_ready = 1'b1;
    #1;
    checks++;
    if (bit_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_release_ready: got %b expected 1", bit_ready);
    end
    step();
    checks++;
    if ({word_valid, word_out, word_count} !== {1'b1, 4'b0000, 8'd1}) begin
      failures++;
      $display("FAIL bp_no_bubble: got %h expected %h", {word_valid, word_out, word_count}, {1'b1, 4'b0000, 8'd1});
    end
    bit_valid = 1'b0;
    step();
    checks++;
    if ({word_valid, word_count} !== {1'b0, 8'd2}) begin
      failures++;
      $display("FAIL bp_drain: got %h expected %h", {word_valid, word_count}, 9'h002);
    end
  endtask

  task automatic test_clear();
    logic [3:0] pat = 4'b0110;
    do_reset();
    word_ready = 1'b1;
    bit_valid  = 1'b1;
    bit_in     = 1'b1;
    repeat (2) step();
    checks++;
    if (fill_level !== 2'd2) begin
      failures++;
      $display("FAIL clear_pre_fill: got %0d expected 2", fill_level);
    end
    clear = 1'b1;
    step();
    clear = 1'b0;
    checks++;
    if ({fill_level, fill_l, word_valid} !== 5'b0) begin
      failures++;
      $display("FAIL clear_flush: got %b expected 00000", {fill_level, fill_l, word_valid});
    end
    for (int i = 0; i < 4; i++) begin
      bit_in = pat[3-i];
      step();
    end
    checks++;
    if ({word_valid, word_out, word_out_l} !== {1'b1, 4'b0110, 4'b0110}) begin
      failures++;
      $display("FAIL clear_next_word: got %b expected %b", {word_valid, word_out, word_out_l}, 9'b1_0110_0110);
    end
    // A pending word is dropped uncounted; word_out keeps its last value.
    word_ready = 1'b0;
    bit_valid  = 1'b0;
    clear      = 1'b1;
    step();
    clear = 1'b0;
    checks++;
    if ({word_valid, word_out, word_count} !== {1'b0, 4'b0110, 8'd0}) begin
      failures++;
      $display("FAIL clear_pending: got %h expected %h", {word_valid, word_out, word_count}, {1'b0, 4'b0110, 8'd0});
    end
    checks++;
    if (act_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL clear_model: got %h expected %h", act_vec(), exp_vec());
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    bit_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      bit_in = 1'($urandom);
      step();
    end
    checks++;
    if ({word_valid, fill_level} !== 3'b1_11) begin
      failures++;
      $display("FAIL areset_setup: got %b expected 111", {word_valid, fill_level});
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ((act_vec() & 32'h7FFF_7FFF) !== 32'h0) begin
      failures++;
      $display("FAIL areset_immediate: got %h expected %h", act_vec() & 32'h7FFF_7FFF, 32'h0);
    end
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    word_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bit_in = 1'($urandom);
      step();
      checks++;
      if (act_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL areset_after: got %h expected %h", act_vec(), exp_vec());
      end
    end
    bit_valid = 1'b0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      bit_valid  = ($urandom_range(0, 3) != 0);
      bit_in     = 1'($urandom);
      word_ready = 1'($urandom_range(0, 1));
      clear      = ($urandom_range(0, 31) == 0);
      step();
      checks++;
      if (act_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL random_cycle%0d: got %h expected %h", n, act_vec(), exp_vec());
      end
    end
    clear = 1'b0;
  endtask

  task automatic test_wrap();
    int nvalid = 0;
    do_reset();
    word_ready = 1'b1;
    bit_valid  = 1'b1;
    for (int n = 0; n < 1024; n++) begin
      bit_in = 1'($urandom);
      step();
      if (word_valid) nvalid++;
      checks++;
      if (act_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL wrap_cycle%0d: got %h expected %h", n, act_vec(), exp_vec());
      end
    end
    checks++;
    if (nvalid !== 256) begin
      failures++;
      $display("FAIL wrap_throughput: got %0d words expected 256", nvalid);
    end
    bit_valid = 1'b0;
    step();
    checks++;
    if ({word_valid, word_count, count_l} !== {1'b0, 8'd0, 8'd0}) begin
      failures++;
      $display("FAIL wrap_count: got %h expected %h", {word_valid, word_count, count_l}, 17'h0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_clear();
    test_async_reset();
    test_random();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_serial_word_packer
`default_nettype wire
